// File: rtl/flash_cmd_addr_tx.sv
// Host-side flash header serializer: drives command, address and dummy phases
// in SPI (1 bit/cycle) or OPI (1 byte/cycle), then holds chip select low.
module flash_cmd_addr_tx #(
    parameter int DUMMY_W = 5
) (
    input  logic               clkm,
    input  logic               rst_n,
    input  logic               start,
    input  logic               mode,
    input  logic               addr4b,
    input  logic [7:0]         cmd,
    input  logic [31:0]        addr_in,
    input  logic [DUMMY_W-1:0] dummy_cyc,
    input  logic               cs_release,
    output logic               cs_n,
    output logic               sck_en,
    output logic [7:0]         io_out,
    output logic               io_oe,
    output logic               busy,
    output logic               done
);

    // state  | meaning
    // IDLE   | cs_n high, waiting for start
    // CMD    | opcode on the bus
    // ADDR   | address on the bus, MSB first
    // DUMMY  | SCK running, bus released
    // HOLD   | header finished, cs_n held low until cs_release
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_HOLD} state_t;

    localparam int CW = (DUMMY_W > 6) ? DUMMY_W : 6;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [7:0]         cmd_q, cmd_d;
    logic [31:0]        addr_q, addr_d;
    logic               mode_q, mode_d;
    logic               addr4b_q, addr4b_d;
    logic [DUMMY_W-1:0] dummy_q, dummy_d;

    logic               cs_n_d, sck_en_d, io_oe_d, busy_d, done_d;
    logic [7:0]         io_out_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cmd_d    = cmd_q;
        addr_d   = addr_q;
        mode_d   = mode_q;
        addr4b_d = addr4b_q;
        dummy_d  = dummy_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cmd_d    = cmd;
                    addr_d   = addr_in;
                    mode_d   = mode;
                    addr4b_d = addr4b;
                    dummy_d  = dummy_cyc;
                    state_d  = S_CMD;
                    cnt_d    = mode ? CW'(0) : CW'(7);
                end
            end
            S_CMD: begin
                if (cnt_q == '0) begin
                    state_d = S_ADDR;
                    if (mode_q) cnt_d = addr4b_q ? CW'(3) : CW'(2);
                    else        cnt_d = addr4b_q ? CW'(31) : CW'(23);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_ADDR: begin
                if (cnt_q == '0) begin
                    if (dummy_q == '0) begin
                        state_d = S_HOLD;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_DUMMY;
                        cnt_d   = CW'(dummy_q) - CW'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DUMMY: begin
                if (cnt_q == '0) state_d = S_HOLD;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_HOLD: begin
                if (cs_release) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state/count so the registered
    // values line up with the phase the FSM is in during that cycle.
    always_comb begin
        cs_n_d   = (state_d == S_IDLE);
        busy_d   = (state_d != S_IDLE);
        sck_en_d = 1'b0;
        io_oe_d  = 1'b0;
        io_out_d = 8'h00;
        done_d   = (state_d == S_HOLD) && (state_q != S_HOLD);
        case (state_d)
            S_CMD: begin
                sck_en_d = 1'b1;
                io_oe_d  = 1'b1;
                io_out_d = mode_d ? cmd_d : {7'b0, cmd_d[cnt_d[2:0]]};
            end
            S_ADDR: begin
                sck_en_d = 1'b1;
                io_oe_d  = 1'b1;
                io_out_d = mode_d ? addr_d[{cnt_d[1:0], 3'b000} +: 8]
                                  : {7'b0, addr_d[cnt_d[4:0]]};
            end
            S_DUMMY: sck_en_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clkm) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            cmd_q    <= '0;
            addr_q   <= '0;
            mode_q   <= 1'b0;
            addr4b_q <= 1'b0;
            dummy_q  <= '0;
            cs_n     <= 1'b1;
            sck_en   <= 1'b0;
            io_out   <= 8'h00;
            io_oe    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            mode_q   <= mode_d;
            addr4b_q <= addr4b_d;
            dummy_q  <= dummy_d;
            cs_n     <= cs_n_d;
            sck_en   <= sck_en_d;
            io_out   <= io_out_d;
            io_oe    <= io_oe_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

endmodule

// File: tb/tb_flash_cmd_addr_tx.sv
// Directed bench for flash_cmd_addr_tx: compares the packed output vector
// {cs_n, sck_en, io_oe, busy, done, io_out} every cycle against expectations.
module tb_flash_cmd_addr_tx;

    logic        clkm = 1'b0;
    logic        rst_n, start, mode, addr4b, cs_release;
    logic [7:0]  cmd;
    logic [31:0] addr_in;
    logic [4:0]  dummy_cyc;
    logic        cs_n, sck_en, io_oe, busy, done;
    logic [7:0]  io_out;
    logic [12:0] obs, expv;

    int checks = 0;
    int errors = 0;

    flash_cmd_addr_tx #(.DUMMY_W(5)) dut (
        .clkm(clkm), .rst_n(rst_n), .start(start), .mode(mode), .addr4b(addr4b),
        .cmd(cmd), .addr_in(addr_in), .dummy_cyc(dummy_cyc), .cs_release(cs_release),
        .cs_n(cs_n), .sck_en(sck_en), .io_out(io_out), .io_oe(io_oe),
        .busy(busy), .done(done)
    );

    always #5 clkm = ~clkm;

    assign obs = {cs_n, sck_en, io_oe, busy, done, io_out};

    function automatic logic [12:0] ev(input logic cs, input logic sck, input logic oe,
                                       input logic bz, input logic dn, input logic [7:0] io);
        return {cs, sck, oe, bz, dn, io};
    endfunction

    localparam logic [12:0] IDLE_V = 13'b1_0_0_0_0_00000000;

    // Expected outputs for cycle i after the accepting edge (i=0 is the first CMD cycle).
    function automatic logic [12:0] exp_cycle(input logic m, input logic a4, input logic [7:0] c,
                                              input logic [31:0] a, input int d, input int i);
        int nc, na, j, k;
        logic [7:0] io;
        nc = m ? 1 : 8;
        na = m ? (a4 ? 4 : 3) : (a4 ? 32 : 24);
        if (i < nc) begin
            io = m ? c : {7'b0, c[7-i]};
            return ev(0, 1, 1, 1, 0, io);
        end
        if (i < nc + na) begin
            j = i - nc;
            k = na - 1 - j;
            io = m ? 8'(a >> (8 * k)) : {7'b0, a[k]};
            return ev(0, 1, 1, 1, 0, io);
        end
        if (i < nc + na + d) return ev(0, 1, 0, 1, 0, 8'h00);
        return ev(0, 0, 0, 1, (i == nc + na + d), 8'h00);
    endfunction

    task automatic launch(input logic m, input logic a4, input logic [7:0] c,
                          input logic [31:0] a, input logic [4:0] d);
        @(negedge clkm);
        mode = m; addr4b = a4; cmd = c; addr_in = a; dummy_cyc = d; start = 1'b1;
        @(negedge clkm);
        start = 1'b0;
    endtask

    task automatic release_cs();
        cs_release = 1'b1;
        @(negedge clkm);
        cs_release = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; addr4b = 1'b0; cs_release = 1'b0;
        cmd = 8'h00; addr_in = 32'h0; dummy_cyc = 5'd0;
        repeat (3) @(negedge clkm);
        checks++;
        if (obs !== IDLE_V) begin
            errors++;
            $display("FAIL reset: got %h expected %h", obs, IDLE_V);
        end
        rst_n = 1'b1;
        @(negedge clkm);
        checks++;
        if (obs !== IDLE_V) begin
            errors++;
            $display("FAIL idle_after_reset: got %h expected %h", obs, IDLE_V);
        end
    endtask

    task automatic test_spi_3b();
        logic [31:0] bits;
        bits = 32'h02_123456;
        launch(0, 0, 8'h02, 32'h0012_3456, 5'd0);
        for (int i = 0; i < 32; i++) begin
            expv = ev(0, 1, 1, 1, 0, {7'b0, bits[31-i]});
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL spi_3b cycle %0d: got %h expected %h", i, obs, expv);
            end
            @(negedge clkm);
        end
        expv = ev(0, 0, 0, 1, 1, 8'h00);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL spi_3b done: got %h expected %h", obs, expv);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clkm);
            expv = ev(0, 0, 0, 1, 0, 8'h00);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL spi_3b hold %0d: got %h expected %h", i, obs, expv);
            end
        end
        release_cs();
        checks++;
        if (obs !== IDLE_V) begin
            errors++;
            $display("FAIL spi_3b release: got %h expected %h", obs, IDLE_V);
        end
    endtask

    task automatic test_opi_4b();
        logic [7:0] b [5];
        b = '{8'hEB, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
        launch(1, 1, 8'hEB, 32'hA1B2_C3D4, 5'd6);
        for (int i = 0; i < 13; i++) begin
            if (i < 5)       expv = ev(0, 1, 1, 1, 0, b[i]);
            else if (i < 11) expv = ev(0, 1, 0, 1, 0, 8'h00);
            else             expv = ev(0, 0, 0, 1, (i == 11), 8'h00);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL opi_4b cycle %0d: got %h expected %h", i, obs, expv);
            end
            @(negedge clkm);
        end
        release_cs();
        checks++;
        if (obs !== IDLE_V) begin
            errors++;
            $display("FAIL opi_4b release: got %h expected %h", obs, IDLE_V);
        end
    endtask

    task automatic test_opi_3b();
        logic [7:0] b [4];
        b = '{8'h0B, 8'h12, 8'h34, 8'h56};
        launch(1, 0, 8'h0B, 32'hFF12_3456, 5'd0);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) expv = ev(0, 1, 1, 1, 0, b[i]);
            else       expv = ev(0, 0, 0, 1, (i == 4), 8'h00);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL opi_3b cycle %0d: got %h expected %h", i, obs, expv);
            end
            @(negedge clkm);
        end
        release_cs();
    endtask

    task automatic test_start_ignored();
        launch(0, 0, 8'h03, 32'h00AB_CDEF, 5'd2);
        for (int i = 0; i < 36; i++) begin
            expv = exp_cycle(0, 0, 8'h03, 32'h00AB_CDEF, 2, i);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL start_ignored cycle %0d: got %h expected %h", i, obs, expv);
            end
            if (i == 12) begin
                start = 1'b1; cmd = 8'h55; addr_in = 32'h0; mode = 1'b1; dummy_cyc = 5'd9;
            end
            if (i == 13) start = 1'b0;
            @(negedge clkm);
        end
        release_cs();
    endtask

    task automatic test_reset_mid();
        launch(0, 1, 8'h13, 32'h89AB_CDEF, 5'd3);
        for (int i = 0; i <= 18; i++) begin
            expv = exp_cycle(0, 1, 8'h13, 32'h89AB_CDEF, 3, i);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL reset_mid pre cycle %0d: got %h expected %h", i, obs, expv);
            end
            if (i < 18) @(negedge clkm);
        end
        rst_n = 1'b0;
        @(negedge clkm);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs !== IDLE_V) begin
                errors++;
                $display("FAIL reset_mid idle %0d: got %h expected %h", i, obs, IDLE_V);
            end
            @(negedge clkm);
        end
        launch(0, 1, 8'h9F, 32'h8000_0001, 5'd3);
        for (int i = 0; i < 45; i++) begin
            expv = exp_cycle(0, 1, 8'h9F, 32'h8000_0001, 3, i);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL reset_mid rerun cycle %0d: got %h expected %h", i, obs, expv);
            end
            @(negedge clkm);
        end
        release_cs();
    endtask

    task automatic test_hold_start();
        launch(1, 0, 8'h6B, 32'h0001_0203, 5'd1);
        for (int i = 0; i < 6; i++) begin
            expv = exp_cycle(1, 0, 8'h6B, 32'h0001_0203, 1, i);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL hold_start cycle %0d: got %h expected %h", i, obs, expv);
            end
            @(negedge clkm);
        end
        cs_release = 1'b1; start = 1'b1; cmd = 8'hC3;
        @(negedge clkm);
        cs_release = 1'b0; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs !== IDLE_V) begin
                errors++;
                $display("FAIL hold_start idle %0d: got %h expected %h", i, obs, IDLE_V);
            end
            @(negedge clkm);
        end
        launch(1, 0, 8'hC3, 32'h0001_0203, 5'd1);
        expv = exp_cycle(1, 0, 8'hC3, 32'h0001_0203, 1, 0);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL hold_start restart: got %h expected %h", obs, expv);
        end
        cs_release = 1'b1;
        @(negedge clkm);
        cs_release = 1'b0;
        expv = exp_cycle(1, 0, 8'hC3, 32'h0001_0203, 1, 1);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL hold_start release_outside_hold: got %h expected %h", obs, expv);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_spi_3b();
        test_opi_4b();
        test_opi_3b();
        test_start_ignored();
        test_reset_mid();
        test_hold_start();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/flash_cmd_addr_tx.md
Name: flash_cmd_addr_tx

Overview:
Host-side serializer that drives the command and address phases of a flash transaction onto the SPI/OPI bus. It is the transmitting counterpart of the flash-side address capture logic. Supports SPI (1 bit/cycle on io_out[0], MSB first) and OPI (1 byte/cycle on io_out[7:0]), with 3- or 4-byte addresses and a programmable dummy phase. Sits between the host transaction controller and the pad/SCK gating logic, and holds chip select low after the header so a following data phase can run.

Parameters:
DUMMY_W, 5, width of dummy_cyc (max dummy count 2^DUMMY_W-1).

Ports:
clkm  input  1  system clock; bus shifts one unit per rising edge.
rst_n  input  1  reset, synchronous, active-low.
start  input  1  request a new header; sampled only in IDLE.
mode  input  1  0=SPI, 1=OPI; latched on accepted start.
addr4b  input  1  1=32-bit address, 0=24-bit (addr_in[23:0]); latched on start.
cmd  input  8  command opcode; latched on start.
addr_in  input  32  transaction address; latched on start.
dummy_cyc  input  DUMMY_W  dummy clock count after address; latched on start.
cs_release  input  1  in HOLD, ends the transaction.
cs_n  output  1  chip select, active-low.
sck_en  output  1  SCK gate enable; high while cmd/addr/dummy bits are on the bus.
io_out  output  8  bus data; SPI uses bit 0, bits 7:1 driven 0.
io_oe  output  1  bus output enable.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse when the header (incl. dummy) completes.

Behaviour:
- Reset (rst_n low at a clkm edge): state=IDLE, cs_n=1, sck_en=0, io_out=0, io_oe=0, busy=0, done=0, counters=0. Applies mid-transaction with no completion pulse.
- States: IDLE, CMD, ADDR, DUMMY, HOLD. All outputs are registered.
- IDLE: start=1 latches cmd/addr_in/mode/addr4b/dummy_cyc. Next edge enters CMD with cs_n=0 and busy=1. start while busy is ignored; inputs are not re-latched.
- CMD: SPI runs 8 cycles, bit7..bit0 on io_out[0]. OPI runs 1 cycle, io_out=cmd. sck_en=1, io_oe=1.
- ADDR: SPI runs 24/32 cycles, MSB first, starting at addr[23] or addr[31]. OPI runs 3/4 cycles as bytes [31:24] (4b only), [23:16], [15:8], [7:0]. sck_en=1, io_oe=1.
- DUMMY: runs dummy_cyc cycles with sck_en=1, io_oe=0, io_out=0. If dummy_cyc=0, ADDR goes directly to HOLD.
- HOLD entry: done=1 for exactly the first HOLD cycle. sck_en=0, io_oe=0, cs_n stays 0, busy=1.
- HOLD: cs_release=1 sets cs_n=1 and busy=0 on the next edge (IDLE). cs_release outside HOLD is ignored.
- cs_n is deasserted for at least 1 cycle between transactions. start on the same edge as the HOLD->IDLE transition is ignored.
- Counters: a single down-counter (6 bits min) loaded at each phase entry with phase length minus 1. Transition occurs when count==0. No wrap.
- Total header cycles: SPI = 8 + 24/32 + dummy. OPI = 1 + 3/4 + dummy.

Test Plan:
- SPI, cmd=0x02, addr_in=0x00123456, addr4b=0, dummy=0 -> cs_n low; io_out[0] serial 0000_0010 then 0x123456 MSB-first over 32 cycles; sck_en high 32 cycles; done pulses on cycle 33; cs_n stays low until cs_release.
- OPI, cmd=0xEB, addr_in=0xA1B2C3D4, addr4b=1, dummy=6 -> io_out EB, A1, B2, C3, D4 on 5 consecutive cycles with io_oe=1; then 6 cycles sck_en=1, io_oe=0; done next cycle.
- OPI, addr4b=0, addr_in=0xFF123456 -> address bytes 12, 34, 56 only; 0xFF never driven.
- start pulsed during ADDR with cmd=0x55 -> ignored; original transaction bits unchanged; busy stays 1.
- rst_n low for 1 cycle during SPI ADDR bit 10 -> next edge: cs_n=1, sck_en=0, io_oe=0, busy=0; no done pulse; a new start then runs normally.
- HOLD with cs_release=1 and start=1 on the same cycle -> IDLE with cs_n=1 for ≥1 cycle; start accepted only when reasserted in IDLE.
